dht11_poll_scheduler: RTL and testbench
=======================================

DHT11_POLL_SCHEDULER -- requirements
Module: dht11_poll_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter PERIOD_MS, default 2000, interval between periodic reads, measured start-to-start.
REQ-003 Parameter MIN_GAP_MS, default 1000, minimum interval between any two reader starts, and power-up settle time.
REQ-004 Parameter TIMEOUT_MS, default 30, maximum time from rd_start to rd_done.
REQ-005 Parameter MAX_RETRY, default 3, number of consecutive failures that raises fault.
REQ-006 Ports, in order:
- clk  in  1  single clock (50 MHz); one clock domain only.
- rst  in  1  reset; synchronous, active-high.
- req_manual  in  1  single-cycle request for an immediate read.
- rd_start  out  1  one-cycle pulse that starts the DHT11 reader transaction.
- rd_abort  out  1  one-cycle pulse that forces the reader back to idle after a timeout.
- rd_done  in  1  one-cycle pulse: reader transaction finished.
- rd_ok  in  1  checksum valid; qualified by rd_done.
- rd_data  in  32  {hum_int, hum_dec, temp_int, temp_dec}; qualified by rd_done.
- sample  out  32  last valid reading.
- sample_valid  out  1  at least one valid reading held since reset.
- new_sample  out  1  one-cycle pulse when sample updates.
- fault  out  1  MAX_RETRY consecutive failures.
- err_cnt  out  8  total failures, saturating.
- busy  out  1  a transaction is in flight (state START or WAIT).

Function
REQ-007 The block SHALL contain a 1 ms tick counter (CLK_HZ/1000 cycles) that all ms timers use; the tick counter SHALL be free-running.
REQ-008 State machine states SHALL be: INIT, IDLE, START, WAIT, GAP.
REQ-009 INIT: wait MIN_GAP_MS ticks, then go to START.
REQ-010 START: assert rd_start for exactly one cycle, clear since_start and to_cnt, then go to WAIT on the next cycle.
REQ-011 since_start: 16-bit ms counter, cleared in START, saturating at 0xFFFF.
REQ-012 WAIT, rd_done=1 and rd_ok=1:
- sample <= rd_data; sample_valid <= 1; new_sample pulses in the following cycle.
- fail_cnt <= 0; fault <= 0.
- Go to IDLE.
REQ-013 WAIT, rd_done=1 and rd_ok=0: failure (REQ-015).
REQ-014 WAIT, to_cnt reaches TIMEOUT_MS without rd_done: pulse rd_abort for one cycle; failure (REQ-015).
REQ-015 Failure handling:
- err_cnt increments, saturating at 255.
- If fail_cnt+1 == MAX_RETRY: fault <= 1, fail_cnt <= 0, go to IDLE.
- Otherwise: fail_cnt increments, go to GAP.
REQ-016 GAP: wait until since_start >= MIN_GAP_MS, then go to START.
REQ-017 IDLE: go to START when since_start >= PERIOD_MS, or when pending=1 and since_start >= MIN_GAP_MS.
REQ-018 pending SHALL set on req_manual in any state and SHALL clear on entry to START; a request therefore never causes more than one extra read.
REQ-019 Boundary cases:
- Periodic and manual triggers in the same cycle: exactly one START.
- rd_done and timeout in the same cycle: rd_done wins, no rd_abort.
- rd_done outside WAIT: ignored.
REQ-020 sample SHALL never change on a failed read; sample keeps its last valid value while fault=1.
REQ-021 rd_start and rd_abort SHALL never be asserted in the same cycle.
REQ-022 busy SHALL equal 1 in START and WAIT only.

Reset
REQ-023 On rst=1 at a clock edge:
- State SHALL go to INIT.
- All counters, pending, and fail_cnt SHALL clear.
- All outputs SHALL go to 0: sample=0, sample_valid=0, new_sample=0, fault=0, err_cnt=0, rd_start=0, rd_abort=0, busy=0.
REQ-024 rst asserted mid-WAIT SHALL NOT pulse rd_abort; the reader shares rst and resets itself.

Structure
REQ-025 A shared package (dht11_pkg) SHALL hold:
- the state enumeration;
- the sample field offsets (HUM_INT=31:24, HUM_DEC=23:16, TEMP_INT=15:8, TEMP_DEC=7:0);
- the default timing constants.
REQ-026 The ms tick generator SHALL be a sub-module named ms_tick (params CLK_HZ; ports clk, rst, tick).

Verification
REQ-027 Bench parameters SHALL be CLK_HZ=10_000 (10 cycles/ms), PERIOD_MS=20, MIN_GAP_MS=10, TIMEOUT_MS=3, MAX_RETRY=3.
REQ-028 Directed scenarios:
- Reset release, reader model returns ok with 0x2A00_1905 after 2 ms -> first rd_start 100 cycles after reset; sample=0x2A001905; new_sample 1 cycle; next rd_start 200 cycles after the first.
- rd_ok=0 three times in a row -> starts spaced 100 cycles apart; err_cnt=3; fault=1; fourth start at 200 cycles after the first; an ok read clears fault.
- No rd_done -> rd_abort exactly 30 cycles after rd_start; no rd_start in the same cycle; err_cnt+1.
- req_manual 50 cycles after a completed start -> rd_start at cycle 100 after that start; a second req_manual during WAIT -> exactly one extra start.
- rd_done and timeout in the same cycle with rd_ok=1 -> sample updates, no rd_abort.
- rst pulsed mid-WAIT -> all outputs 0 next cycle; INIT timing restarts (rd_start 100 cycles later).

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 poll scheduler: FSM encoding, sample field
// layout and default timing constants.
package dht11_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  // Layout of a 32-bit reading: {hum_int, hum_dec, temp_int, temp_dec}
  localparam int HUM_INT_MSB  = 31;
  localparam int HUM_INT_LSB  = 24;
  localparam int HUM_DEC_MSB  = 23;
  localparam int HUM_DEC_LSB  = 16;
  localparam int TEMP_INT_MSB = 15;
  localparam int TEMP_INT_LSB = 8;
  localparam int TEMP_DEC_MSB = 7;
  localparam int TEMP_DEC_LSB = 0;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_PERIOD_MS  = 2000;
  localparam int DEF_MIN_GAP_MS = 1000;
  localparam int DEF_TIMEOUT_MS = 30;
  localparam int DEF_MAX_RETRY  = 3;

  // Millisecond counter step: +1 on tick, sticking at 0xFFFF.
  function automatic logic [15:0] ms_inc(input logic [15:0] v, input logic tick);
    return (tick && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running 1 ms strobe: one cycle high every CLK_HZ/1000 clocks.
module ms_tick
  import dht11_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int W   = $clog2(DIV + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/dht11_poll_scheduler.sv
// Schedules DHT11 reads: settle after power-up, periodic and manual reads,
// timeout/abort of a stuck reader, retry spacing and fault tracking.
module dht11_poll_scheduler
  import dht11_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int PERIOD_MS  = DEF_PERIOD_MS,
  parameter int MIN_GAP_MS = DEF_MIN_GAP_MS,
  parameter int TIMEOUT_MS = DEF_TIMEOUT_MS,
  parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_manual,
  output logic        rd_start,
  output logic        rd_abort,
  input  logic        rd_done,
  input  logic        rd_ok,
  input  logic [31:0] rd_data,
  output logic [31:0] sample,
  output logic        sample_valid,
  output logic        new_sample,
  output logic        fault,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  // Strobe semantics: req_manual, rd_start, rd_abort, rd_done and new_sample
  // are single-cycle pulses; rd_ok/rd_data are only looked at while rd_done=1.

  localparam logic [15:0] PERIOD_T  = 16'(PERIOD_MS);
  localparam logic [15:0] GAP_T     = 16'(MIN_GAP_MS);
  localparam logic [15:0] TIMEOUT_T = 16'(TIMEOUT_MS);
  localparam logic [7:0]  RETRY_T   = 8'(MAX_RETRY);

  logic        tick;
  state_t      state;
  logic [15:0] init_cnt, since_start, to_cnt;
  logic [15:0] init_next, since_next, to_next;
  logic [7:0]  fail_cnt;
  logic        pending;
  logic        fail_now;

  ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Comparisons use the post-tick value so a transition lands on the tick edge.
  assign init_next  = ms_inc(init_cnt, tick);
  assign since_next = ms_inc(since_start, tick);
  assign to_next    = ms_inc(to_cnt, tick);

  assign fail_now = (state == ST_WAIT) &&
                    (rd_done ? !rd_ok : (to_next >= TIMEOUT_T));

  assign rd_start = (state == ST_START);
  assign busy     = (state == ST_START) || (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      since_start  <= '0;
      to_cnt       <= '0;
      fail_cnt     <= '0;
      pending      <= 1'b0;
      rd_abort     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      new_sample   <= 1'b0;
      fault        <= 1'b0;
      err_cnt      <= '0;
    end else begin
      rd_abort    <= 1'b0;
      new_sample  <= 1'b0;
      since_start <= since_next;
      if (req_manual) pending <= 1'b1;

      case (state)
        ST_INIT: begin
          init_cnt <= init_next;
          if (init_next >= GAP_T) begin
            state   <= ST_START;
            pending <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (since_next >= PERIOD_T || (pending && since_next >= GAP_T)) begin
            state   <= ST_START;
            pending <= 1'b0;
          end
        end
        ST_START: begin
          since_start <= '0;
          to_cnt      <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          to_cnt <= to_next;
          if (rd_done && rd_ok) begin
            sample       <= rd_data;
            sample_valid <= 1'b1;
            new_sample   <= 1'b1;
            fail_cnt     <= '0;
            fault        <= 1'b0;
            state        <= ST_IDLE;
          end else if (fail_now) begin
            // A reader that answered (even badly) is already idle; only a silent one is aborted.
            if (!rd_done) rd_abort <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (fail_cnt + 8'd1 == RETRY_T) begin
              fault    <= 1'b1;
              fail_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              fail_cnt <= fail_cnt + 8'd1;
              state    <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (since_next >= GAP_T) begin
            state   <= ST_START;
            pending <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Directed bench for dht11_poll_scheduler at 10 cycles/ms: start spacing,
// retries/fault, timeout abort, manual requests and reset behaviour.
module tb_dht11_poll_scheduler;

  localparam int CLK_HZ     = 10_000;
  localparam int PERIOD_MS  = 20;
  localparam int MIN_GAP_MS = 10;
  localparam int TIMEOUT_MS = 3;
  localparam int MAX_RETRY  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_manual = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_ok = 1'b0;
  logic [31:0] rd_data = '0;
  logic        rd_start, rd_abort, sample_valid, new_sample, fault, busy;
  logic [31:0] sample;
  logic [7:0]  err_cnt;

  dht11_poll_scheduler #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .MIN_GAP_MS(MIN_GAP_MS),
    .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .req_manual(req_manual),
    .rd_start(rd_start), .rd_abort(rd_abort),
    .rd_done(rd_done), .rd_ok(rd_ok), .rd_data(rd_data),
    .sample(sample), .sample_valid(sample_valid), .new_sample(new_sample),
    .fault(fault), .err_cnt(err_cnt), .busy(busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks; all are entered and left on a falling edge.
  task automatic wait_start(input int budget, output int at);
    int i;
    bit seen;
    i = 0;
    seen = 1'b0;
    at = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      i++;
      if (rd_start) begin
        seen = 1'b1;
        at = cyc;
        check("start_without_abort", 32'(rd_abort), 32'd0);
      end
    end
    if (!seen) at = cyc;
  endtask

  task automatic wait_abort(input int budget, output int at);
    int i;
    bit seen;
    i = 0;
    seen = 1'b0;
    at = 0;
    while (!seen && i < budget) begin
      @(negedge clk);
      i++;
      if (rd_abort) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    if (!seen) at = cyc;
  endtask

  task automatic respond(input int delay, input logic ok, input logic [31:0] data);
    repeat (delay) @(negedge clk);
    rd_done = 1'b1;
    rd_ok   = ok;
    rd_data = data;
    @(negedge clk);
    rd_done = 1'b0;
    rd_ok   = 1'b0;
    rd_data = '0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_manual();
    req_manual = 1'b1;
    @(negedge clk);
    req_manual = 1'b0;
  endtask

  // Scoreboard: every accepted reading must surface as new_sample + sample.
  task automatic ok_read(input string tag, input int delay, input logic [31:0] data);
    exp_q.push_back(data);
    respond(delay, 1'b1, data);
    check({tag, "_new_sample"}, 32'(new_sample), 32'd1);
    check({tag, "_sample"}, sample, exp_q.pop_front());
    check({tag, "_valid"}, 32'(sample_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"}, sample, 32'd0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_new_sample"}, 32'(new_sample), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_rd_start"}, 32'(rd_start), 32'd0);
    check({tag, "_rd_abort"}, 32'(rd_abort), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int t0, t1, a;
  int s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, s12;

  initial begin
    // Reset and settle: first start 10 ms after release
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    t0 = cyc;
    wait_start(150, s1);
    check("first_start_delay", 32'(s1 - t0), 32'd100);
    check("busy_in_start", 32'(busy), 32'd1);
    ok_read("read1", 20, 32'h2A00_1905);
    check("busy_after_ok", 32'(busy), 32'd0);
    @(negedge clk);
    check("new_sample_one_cycle", 32'(new_sample), 32'd0);

    // rd_done outside WAIT is ignored
    wait_until(s1 + 60);
    respond(0, 1'b1, 32'hDEAD_BEEF);
    check("stray_done_no_new", 32'(new_sample), 32'd0);
    check("stray_done_sample", sample, 32'h2A00_1905);
    wait_start(300, s2);
    check("periodic_spacing", 32'(s2 - s1), 32'd200);

    // Three checksum failures in a row -> fault
    respond(20, 1'b0, 32'h1111_1111);
    check("fail1_err_cnt", 32'(err_cnt), 32'd1);
    check("fail1_fault", 32'(fault), 32'd0);
    check("fail1_sample", sample, 32'h2A00_1905);
    wait_start(200, s3);
    check("retry1_spacing", 32'(s3 - s2), 32'd100);
    respond(20, 1'b0, 32'h2222_2222);
    check("fail2_err_cnt", 32'(err_cnt), 32'd2);
    wait_start(200, s4);
    check("retry2_spacing", 32'(s4 - s3), 32'd100);
    respond(20, 1'b0, 32'h3333_3333);
    check("fail3_err_cnt", 32'(err_cnt), 32'd3);
    check("fail3_fault", 32'(fault), 32'd1);
    check("fault_sample_held", sample, 32'h2A00_1905);
    check("fault_not_busy", 32'(busy), 32'd0);
    wait_start(400, s5);
    check("after_fault_spacing", 32'(s5 - s4), 32'd200);
    ok_read("recover", 20, 32'h3000_1A02);
    check("recover_fault_clear", 32'(fault), 32'd0);

    // Silent reader -> abort 3 ms after start
    wait_start(300, s6);
    check("pre_timeout_spacing", 32'(s6 - s5), 32'd200);
    wait_abort(50, a);
    check("abort_delay", 32'(a - s6), 32'd30);
    check("abort_no_start", 32'(rd_start), 32'd0);
    check("timeout_err_cnt", 32'(err_cnt), 32'd4);
    check("timeout_no_fault", 32'(fault), 32'd0);
    @(negedge clk);
    check("abort_one_cycle", 32'(rd_abort), 32'd0);
    wait_start(200, s7);
    check("timeout_retry_spacing", 32'(s7 - s6), 32'd100);
    ok_read("after_timeout", 20, 32'h2200_1500);

    // Manual requests: one mid-IDLE, one during WAIT
    wait_until(s7 + 50);
    pulse_manual();
    wait_start(200, s8);
    check("manual_spacing", 32'(s8 - s7), 32'd100);
    wait_until(s8 + 5);
    pulse_manual();
    ok_read("manual1", 14, 32'h2300_1600);
    wait_start(200, s9);
    check("manual_in_wait_spacing", 32'(s9 - s8), 32'd100);
    ok_read("manual2", 20, 32'h2400_1700);
    wait_start(300, s10);
    check("no_extra_start", 32'(s10 - s9), 32'd200);

    // rd_done on the timeout edge wins
    ok_read("done_at_timeout", 29, 32'h1B2C_3D4E);
    check("done_at_timeout_no_abort", 32'(rd_abort), 32'd0);
    check("done_at_timeout_err_cnt", 32'(err_cnt), 32'd4);

    // Reset in the middle of WAIT
    wait_start(300, s11);
    check("pre_reset_spacing", 32'(s11 - s10), 32'd200);
    wait_until(s11 + 5);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_wait_reset");
    rst = 1'b0;
    t1 = cyc;
    wait_start(150, s12);
    check("restart_delay", 32'(s12 - t1), 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
